// File: rtl/ibuf_pkg.sv
// Shared constants, FSM encoding and address-range helper for the
// instruction-buffer fetch controller.
package ibuf_pkg;

  localparam int IBUF_ADDR_W     = 15;
  localparam int IBUF_DATA_W     = 128;
  localparam int IBUF_BANK_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } ibuf_state_e;

  // One past the highest valid word address, one bit wider than an address
  // so that a fully populated buffer still has a representable limit.
  function automatic logic [IBUF_ADDR_W:0] ibuf_addr_limit(input int num_banks);
    return (IBUF_ADDR_W + 1)'(num_banks * IBUF_BANK_DEPTH);
  endfunction

endpackage

// File: rtl/ibuf_addr_gen.sv
// Burst address generator: holds the current read address (wrapping at the
// top of the populated banks) and the number of beats still to issue.
module ibuf_addr_gen
  import ibuf_pkg::*;
#(
  parameter int NUM_BANKS = 24,
  parameter int LEN_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   step,
  input  logic [IBUF_ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]       load_len,
  output logic [IBUF_ADDR_W-1:0] addr,
  output logic                   last
);

  localparam logic [IBUF_ADDR_W:0]   ADDR_LIMIT = ibuf_addr_limit(NUM_BANKS);
  localparam logic [IBUF_ADDR_W-1:0] ADDR_TOP   =
    IBUF_ADDR_W'(ADDR_LIMIT - (IBUF_ADDR_W + 1)'(1));

  logic [LEN_W-1:0] remaining;

  // Load a new descriptor, or advance one beat on every accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr <= (addr == ADDR_TOP) ? '0 : addr + 1'b1;
      if (remaining != '0) remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == '0);

endmodule

// File: rtl/ibuf_fetch_ctrl.sv
// Burst-read sequencer for instruction-buffer port a. Takes one descriptor
// at a time, issues credit-limited single-beat reads and passes returned
// data straight through to the fetch unit; flush drops in-flight data.
// Optional build macro IBUF_FETCH_PERF_EN adds perf_beats/perf_stall.
module ibuf_fetch_ctrl
  import ibuf_pkg::*;
#(
  parameter int NUM_BANKS = 24,
  parameter int MAX_OUTST = 4,
  parameter int LEN_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [IBUF_ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]       req_len,
  input  logic                   flush,
  output logic                   ib_cen,
  output logic                   ib_wen,
  output logic                   ib_last,
  output logic [IBUF_ADDR_W-1:0] ib_addr,
  input  logic                   ib_ready,
  input  logic [IBUF_DATA_W-1:0] ib_rdata,
  input  logic                   ib_rvalid,
  input  logic                   ib_rlast,
  output logic                   ib_rready,
  output logic                   out_valid,
  output logic [IBUF_DATA_W-1:0] out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   err_addr
`ifdef IBUF_FETCH_PERF_EN
  ,
  output logic [31:0]            perf_beats,
  output logic [31:0]            perf_stall
`endif
);

  localparam int                     OUTST_W    = $clog2(MAX_OUTST + 1);
  localparam logic [OUTST_W-1:0]     OUTST_MAX  = OUTST_W'(MAX_OUTST);
  localparam logic [IBUF_ADDR_W:0]   ADDR_LIMIT = ibuf_addr_limit(NUM_BANKS);

  ibuf_state_e          state;
  logic [OUTST_W-1:0]   outst;
  logic                 last_seen;
  logic                 req_hs;
  logic                 addr_bad;
  logic                 credit_ok;
  logic                 flushing;
  logic                 issue_hs;
  logic                 return_hs;
  logic                 beat_last;

  assign req_hs    = req_valid && req_ready;
  assign addr_bad  = ({1'b0, req_addr} >= ADDR_LIMIT);
  assign credit_ok = (outst < OUTST_MAX);
  assign flushing  = (state == FLUSH) || (flush && (state != IDLE));

  assign ib_cen    = (state == ISSUE) && credit_ok && !flush;
  assign ib_wen    = 1'b0;
  assign ib_last   = (state == ISSUE) && beat_last;
  assign issue_hs  = ib_cen && ib_ready;

  assign ib_rready = flushing ? 1'b1 : out_ready;
  assign return_hs = ib_rvalid && ib_rready;
  assign out_valid = ib_rvalid && !flushing;
  assign out_data  = ib_rdata;
  assign out_last  = ib_rlast;
  assign busy      = (state != IDLE);

  ibuf_addr_gen #(
    .NUM_BANKS (NUM_BANKS),
    .LEN_W     (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (req_hs),
    .step      (issue_hs),
    .load_addr (req_addr),
    .load_len  (req_len),
    .addr      (ib_addr),
    .last      (beat_last)
  );

  // Reads issued but not yet returned; bounded by the credit gate on ib_cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else if (issue_hs && !return_hs) begin
      outst <= outst + 1'b1;
    end else if (!issue_hs && return_hs && (outst != '0)) begin
      outst <= outst - 1'b1;
    end
  end

  // Sequencer FSM with registered req_ready, error flag and last-beat tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      err_addr  <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      if (out_valid && out_ready && out_last) last_seen <= 1'b1;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_hs) begin
            err_addr  <= addr_bad;
            last_seen <= 1'b0;
            if (!addr_bad) begin
              state     <= ISSUE;
              req_ready <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (flush)                      state <= FLUSH;
          else if (issue_hs && beat_last) state <= WAIT;
        end
        WAIT: begin
          if (flush) begin
            state <= FLUSH;
          end else if ((outst == '0) && last_seen) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        FLUSH: begin
          if (outst == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IBUF_FETCH_PERF_EN
  logic stall_cycle;
  assign stall_cycle = (state == ISSUE) && !flush && (!credit_ok || !ib_ready);

  // Saturating counters for delivered beats and issue stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready && (perf_beats != '1)) perf_beats <= perf_beats + 1'b1;
      if (stall_cycle && (perf_stall != '1))            perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: doc/ibuf_fetch_ctrl.md
Name: ibuf_fetch_ctrl

Overview:
Burst-read sequencer for port a of the instruction buffer (24 banks x 1024 x 128b, 15-bit word address). Accepts one fetch descriptor (start word address, beat count), issues consecutive single-beat reads with `last` on the final beat, and forwards returned data downstream. Limits in-flight reads to a credit count and supports flush with discard of in-flight data. Sits between the instruction-fetch front end and the buffer.

Parameters:
- NUM_BANKS, 24, number of 1024-word banks; the valid address range is 0 .. NUM_BANKS*1024-1.
- MAX_OUTST, 4, maximum number of reads issued but not yet returned (range 1..7).
- LEN_W, 8, width of the beat-count field; a descriptor covers len+1 beats.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  descriptor valid
- req_ready  out  1  descriptor accepted when valid&&ready
- req_addr  in  15  start word address
- req_len  in  LEN_W  beats minus one
- flush  in  1  abort the current descriptor; one-cycle pulse
- ib_cen  out  1  read request to buffer port a
- ib_wen  out  1  tied 0
- ib_last  out  1  final beat of the descriptor
- ib_addr  out  15  read address
- ib_ready  in  1  buffer accepts request (ib_cen&&ib_ready)
- ib_rdata  in  128  read data
- ib_rvalid  in  1  read data valid
- ib_rlast  in  1  last-beat tag returned with the data
- ib_rready  out  1  read-data accept
- out_valid  out  1  data to fetch unit
- out_data  out  128  data
- out_last  out  1  final beat of the descriptor
- out_ready  in  1  fetch unit accepts
- busy  out  1  state != IDLE
- err_addr  out  1  sticky: a descriptor started at or beyond the valid address range; cleared by the next accepted request

Behaviour:
- Reset values: all outputs 0, state IDLE, outst=0, beat counter 0, err_addr 0.
- States: IDLE, ISSUE, WAIT, FLUSH.
- IDLE: req_ready=1. On req_valid:
  - latch addr and len.
  - If req_addr >= NUM_BANKS*1024: set err_addr, stay IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - ib_cen=1 when outst<MAX_OUTST.
  - ib_last = (remaining beats == 0).
  - On a handshake: addr increments and wraps from NUM_BANKS*1024-1 to 0; remaining decrements. The final handshake moves the FSM to WAIT.
- WAIT: once outst==0 and the last beat has been delivered downstream, go to IDLE.
- outst counter:
  - +1 on ib_cen&&ib_ready; -1 on ib_rvalid&&ib_rready. A simultaneous +1/-1 leaves it unchanged.
  - Never exceeds MAX_OUTST; the width is clog2(MAX_OUTST+1).
- Data path:
  - Combinational pass-through: out_valid=ib_rvalid, out_data=ib_rdata, out_last=ib_rlast, ib_rready=out_ready. No added latency.
  - Buffer read latency is 2 cycles minimum when ready.
- flush, in any state except IDLE:
  - ib_cen drops in the same cycle.
  - Go to FLUSH: out_valid forced 0, ib_rready forced 1. Returning data is discarded and decrements outst.
  - When outst==0, go to IDLE.
  - flush in IDLE: ignored.
  - flush together with a request handshake in ISSUE: that read counts as outstanding and is discarded.
- req_ready=0 outside IDLE; a descriptor arriving with flush in IDLE is accepted and the flush is ignored.
- Reset asserted mid-burst: all state clears at once. The buffer's in-flight data is the system's responsibility.
- len=0: a single beat with ib_last=1.

Optional Feature:
- Macro IBUF_FETCH_PERF_EN.
- When defined, two extra outputs are present:
  - perf_beats (32-bit): counts delivered out_valid&&out_ready beats.
  - perf_stall (32-bit): counts ISSUE cycles with ib_cen=1 && ib_ready=0, plus cycles blocked by credit.
  - Both counters saturate at all-ones and reset to 0.
- When not defined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package ibuf_pkg:
  - IBUF_ADDR_W=15, IBUF_DATA_W=128, IBUF_BANK_DEPTH=1024.
  - FSM state encoding (IDLE=2'd0, ISSUE=1, WAIT=2, FLUSH=3).
- Sub-module ibuf_addr_gen: address register, wrap compare and remaining-beat counter, with load/step inputs and a last output.

Test Plan:
- req_addr=0x0100, len=3, out_ready=1 → ib_addr 0x100..0x103 on consecutive cycles, ib_last only on 0x103; four out beats, out_last on the 4th; busy falls after the 4th beat.
- req_addr=0x5FFE (24574), len=3 → addresses 0x5FFE, 0x5FFF, 0x0000, 0x0001.
- out_ready=0 held, len=15, MAX_OUTST=4, ib_ready=1 → exactly 4 ib_cen handshakes, then ib_cen=0 until out_ready rises.
- flush pulsed after 2 of 8 issues with 2 outstanding → ib_cen=0 that cycle, both returns discarded (out_valid=0), IDLE with outst=0, req_ready=1.
- req_addr=0x6000 → err_addr=1, no ib_cen, req_ready stays 1; next valid request clears err_addr.
- len=0 with ib_ready stalled 3 cycles → ib_cen held with stable addr and ib_last=1 until the handshake; a single out beat with out_last=1.
